// File: rtl/alu_arbiter_if.sv
// Request, shared-ALU and response signals for alu_arbiter.
// The slave modport is the arbiter; master is the requester/consumer side.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [3:0]            req0_opcode;
  logic [DATA_WIDTH-1:0] req0_a;
  logic [DATA_WIDTH-1:0] req0_b;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [3:0]            req1_opcode;
  logic [DATA_WIDTH-1:0] req1_a;
  logic [DATA_WIDTH-1:0] req1_b;

  logic [3:0]            alu_opcode;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [DATA_WIDTH-1:0] alu_result;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport slave (
    input  req0_valid, req0_opcode, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_opcode, req1_a, req1_b,
    output req1_ready,
    output alu_opcode, alu_a, alu_b,
    input  alu_result,
    output rsp_valid, rsp_id, rsp_data,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_opcode, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_opcode, req1_a, req1_b,
    input  req1_ready,
    input  alu_opcode, alu_a, alu_b,
    output alu_result,
    input  rsp_valid, rsp_id, rsp_data,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of one shared combinational ALU, with a
// one-deep tagged response register. Round-robin or port-0 fixed priority.
module alu_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);
  logic                  rsp_valid_q;
  logic                  rsp_id_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  ptr_q;

  logic free;
  logic grant_any;
  logic grant_id;
  logic accept;

  always_comb begin
    free      = !rsp_valid_q || bus.rsp_ready;
    grant_any = bus.req0_valid || bus.req1_valid;
    // Port 1 wins when alone, or under contention when the pointer names it.
    grant_id  = bus.req1_valid &&
                (!bus.req0_valid || ((FIXED_PRIORITY == 0) && ptr_q));
    accept    = free && grant_any;
  end

  assign bus.req0_ready = accept && !grant_id;
  assign bus.req1_ready = accept && grant_id;

  // With no grant grant_id is 0, so the ALU idles on port 0's fields.
  assign bus.alu_opcode = grant_id ? bus.req1_opcode : bus.req0_opcode;
  assign bus.alu_a      = grant_id ? bus.req1_a      : bus.req0_a;
  assign bus.alu_b      = grant_id ? bus.req1_b      : bus.req0_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      ptr_q       <= 1'b0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= grant_id;
      rsp_data_q  <= bus.alu_result;
      if (FIXED_PRIORITY == 0) ptr_q <= !grant_id;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: round-robin instance plus a fixed-priority
// instance, each fed by a small reference ALU.
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_OR = 4'd3, OP_SLT = 4'd5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_WIDTH(DW)) brr ();
  alu_arbiter_if #(.DATA_WIDTH(DW)) bfp ();

  alu_arbiter #(.DATA_WIDTH(DW), .FIXED_PRIORITY(0)) u_rr (.clk(clk), .rst_n(rst_n), .bus(brr));
  alu_arbiter #(.DATA_WIDTH(DW), .FIXED_PRIORITY(1)) u_fp (.clk(clk), .rst_n(rst_n), .bus(bfp));

  function automatic logic [DW-1:0] alu_f(logic [3:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_OR:   return a | b;
      OP_SLT:  return {{(DW-1){1'b0}}, $signed(a) < $signed(b)};
      default: return '0;
    endcase
  endfunction

  always_comb brr.alu_result = alu_f(brr.alu_opcode, brr.alu_a, brr.alu_b);
  always_comb bfp.alu_result = alu_f(bfp.alu_opcode, bfp.alu_a, bfp.alu_b);

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    brr.req0_valid = 0; brr.req0_opcode = OP_ADD; brr.req0_a = 0; brr.req0_b = 0;
    brr.req1_valid = 0; brr.req1_opcode = OP_ADD; brr.req1_a = 0; brr.req1_b = 0;
    brr.rsp_ready  = 1;
    bfp.req0_valid = 0; bfp.req0_opcode = OP_ADD; bfp.req0_a = 0; bfp.req0_b = 0;
    bfp.req1_valid = 0; bfp.req1_opcode = OP_ADD; bfp.req1_a = 0; bfp.req1_b = 0;
    bfp.rsp_ready  = 1;

    #1;
    chk("reset_valid", brr.rsp_valid, 0);
    chk("reset_id", brr.rsp_id, 0);
    chk("reset_data", brr.rsp_data, 0);
    tick(); tick();
    rst_n = 1;

    // Contention, round-robin: 0,1,0,1
    brr.req0_valid = 1; brr.req0_opcode = OP_SUB; brr.req0_a = 10;    brr.req0_b = 3;
    brr.req1_valid = 1; brr.req1_opcode = OP_OR;  brr.req1_a = 'hF0;  brr.req1_b = 'h0F;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ready0", brr.req0_ready, (i % 2) == 0);
      chk("rr_ready1", brr.req1_ready, (i % 2) == 1);
      tick();
      chk("rr_valid", brr.rsp_valid, 1);
      chk("rr_id", brr.rsp_id, i % 2);
      chk("rr_data", brr.rsp_data, (i % 2) ? 'hFF : 7);
    end
    brr.req0_valid = 0; brr.req1_valid = 0;
    tick();
    chk("drain_valid", brr.rsp_valid, 0);

    // Single requester ADD 5+7
    brr.req0_valid = 1; brr.req0_opcode = OP_ADD; brr.req0_a = 5; brr.req0_b = 7;
    #1;
    chk("single_ready0", brr.req0_ready, 1);
    chk("single_ready1", brr.req1_ready, 0);
    chk("single_alu_a", brr.alu_a, 5);
    tick();
    chk("single_valid", brr.rsp_valid, 1);
    chk("single_id", brr.rsp_id, 0);
    chk("single_data", brr.rsp_data, 12);

    // Backpressure with both valid; pointer now prefers port 1
    brr.rsp_ready = 0;
    brr.req0_valid = 1; brr.req0_opcode = OP_SUB; brr.req0_a = 10;   brr.req0_b = 3;
    brr.req1_valid = 1; brr.req1_opcode = OP_OR;  brr.req1_a = 'hF0; brr.req1_b = 'h0F;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready0", brr.req0_ready, 0);
      chk("bp_ready1", brr.req1_ready, 0);
      tick();
      chk("bp_valid", brr.rsp_valid, 1);
      chk("bp_data", brr.rsp_data, 12);
    end
    brr.rsp_ready = 1;
    #1;
    chk("bp_release_ready1", brr.req1_ready, 1);
    chk("bp_release_ready0", brr.req0_ready, 0);
    tick();
    chk("bp_release_valid", brr.rsp_valid, 1);
    chk("bp_release_id", brr.rsp_id, 1);
    chk("bp_release_data", brr.rsp_data, 'hFF);
    brr.req1_valid = 0;
    #1;
    chk("bp_next_ready0", brr.req0_ready, 1);
    tick();
    chk("bp_next_id", brr.rsp_id, 0);
    chk("bp_next_data", brr.rsp_data, 7);

    // Signed compare from port 1 while port 0 idles with different fields
    brr.req0_valid = 0; brr.req0_opcode = OP_ADD; brr.req0_a = 0; brr.req0_b = 0;
    brr.req1_valid = 1; brr.req1_opcode = OP_SLT; brr.req1_a = 'hFFFF_FFFF; brr.req1_b = 1;
    #1;
    chk("slt_ready1", brr.req1_ready, 1);
    chk("slt_alu_op", brr.alu_opcode, OP_SLT);
    tick();
    chk("slt_valid", brr.rsp_valid, 1);
    chk("slt_id", brr.rsp_id, 1);
    chk("slt_data", brr.rsp_data, 1);

    // Port 0 ADD leaves the pointer on port 1 before reset
    brr.req1_valid = 0;
    brr.req0_valid = 1; brr.req0_opcode = OP_ADD; brr.req0_a = 1; brr.req0_b = 1;
    tick();
    chk("pre_reset_data", brr.rsp_data, 2);
    brr.req0_valid = 0; brr.rsp_ready = 0;
    #1;
    rst_n = 0;
    #1;
    chk("async_reset_valid", brr.rsp_valid, 0);
    chk("async_reset_data", brr.rsp_data, 0);
    tick();
    rst_n = 1;
    brr.rsp_ready = 1;
    brr.req0_valid = 1; brr.req0_opcode = OP_SUB; brr.req0_a = 10;   brr.req0_b = 3;
    brr.req1_valid = 1; brr.req1_opcode = OP_OR;  brr.req1_a = 'hF0; brr.req1_b = 'h0F;
    #1;
    chk("post_reset_ready0", brr.req0_ready, 1);
    chk("post_reset_ready1", brr.req1_ready, 0);
    tick();
    chk("post_reset_id", brr.rsp_id, 0);
    brr.req0_valid = 0; brr.req1_valid = 0;

    // Fixed priority instance
    bfp.req0_valid = 1; bfp.req0_opcode = OP_SUB; bfp.req0_a = 10;   bfp.req0_b = 3;
    bfp.req1_valid = 1; bfp.req1_opcode = OP_OR;  bfp.req1_a = 'hF0; bfp.req1_b = 'h0F;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fp_ready0", bfp.req0_ready, 1);
      chk("fp_ready1", bfp.req1_ready, 0);
      tick();
      chk("fp_id", bfp.rsp_id, 0);
      chk("fp_data", bfp.rsp_data, 7);
    end
    bfp.req0_valid = 0;
    #1;
    chk("fp_alone_ready1", bfp.req1_ready, 1);
    tick();
    chk("fp_alone_id", bfp.rsp_id, 1);
    chk("fp_alone_data", bfp.rsp_data, 'hFF);
    bfp.req1_valid = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
